// File: rtl/nibble_serial_cl_subtractor_if.sv
// Start/done handshake bundle for nibble_serial_cl_subtractor.
// OVF is only present when SUB_OVF_EN is defined.
interface nibble_serial_cl_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BIN;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             BOUT;
`ifdef SUB_OVF_EN
  logic             OVF;

  modport master (output start, A, B, BIN, input busy, done, D, BOUT, OVF);
  modport slave  (input start, A, B, BIN, output busy, done, D, BOUT, OVF);
`else
  modport master (output start, A, B, BIN, input busy, done, D, BOUT);
  modport slave  (input start, A, B, BIN, output busy, done, D, BOUT);
`endif
endinterface

// File: rtl/nibble_serial_cl_subtractor.sv
// Multi-cycle D = A - B - BIN, one 4-bit borrow-lookahead nibble per clock, LSB first.
// Define SUB_OVF_EN to add the signed-overflow output OVF.
module nibble_serial_cl_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                           clk,
  input logic                           rst,
  nibble_serial_cl_subtractor_if.slave  bus
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {borrow_out, diff[3:0]}; borrows are fully expanded so no bit ripples.
  function automatic logic [4:0] cla_sub4(input logic [3:0] a, input logic [3:0] b,
                                          input logic bin);
    logic [3:0] g;
    logic [3:0] p;
    logic       b1;
    logic       b2;
    logic       b3;
    logic       bo;
    g  = ~a & b;
    p  = ~a | b;
    b1 = g[0] | (p[0] & bin);
    b2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    b3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
    bo = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & bin);
    return {bo, a ^ b ^ {b3, b2, b1, bin}};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             br_r;
  logic [CW-1:0]    k_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] d_r;
  logic             bout_r;
  logic [3:0]       a_nib_s;
  logic [3:0]       b_nib_s;
  logic [4:0]       nib_s;
  logic             last_s;
`ifdef SUB_OVF_EN
  logic             ovf_r;
`endif

  // Selects the current operand nibbles and evaluates the lookahead slice.
  always_comb begin
    a_nib_s = a_r[{k_r, 2'b00} +: 4];
    b_nib_s = b_r[{k_r, 2'b00} +: 4];
    nib_s   = cla_sub4(a_nib_s, b_nib_s, br_r);
    last_s  = (k_r == LAST_K);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      br_r    <= 1'b0;
      k_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      d_r     <= '0;
      bout_r  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.A;
            b_r     <= bus.B;
            br_r    <= bus.BIN;
            k_r     <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          d_r[{k_r, 2'b00} +: 4] <= nib_s[3:0];
          br_r <= nib_s[4];
          k_r  <= k_r + CW'(1);
          if (last_s) begin
            bout_r  <= nib_s[4];
`ifdef SUB_OVF_EN
            // Signs of A and B differ and the result sign differs from A.
            ovf_r   <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (a_r[WIDTH-1] ^ nib_s[3]);
`endif
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.D    = d_r;
  assign bus.BOUT = bout_r;
`ifdef SUB_OVF_EN
  assign bus.OVF  = ovf_r;
`endif

endmodule

// File: tb/tb_nibble_serial_cl_subtractor.sv
// Self-checking bench: directed cases plus random operands against an arithmetic reference.
// Honours SUB_OVF_EN for the OVF checks.
module tb_nibble_serial_cl_subtractor;

  localparam int W = 16;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  nibble_serial_cl_subtractor_if #(.WIDTH(W)) bus ();

  nibble_serial_cl_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation: reference computed with plain integer arithmetic.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit glitch);
    logic [W-1:0] exp_d;
    logic         exp_bout;
    logic         exp_ovf;
    int           sd;
    int           cnt;
    int           dones;
    exp_d    = W'(int'(a) - int'(b) - int'(bin));
    exp_bout = (int'(a) < (int'(b) + int'(bin)));
    sd       = int'($signed(a)) - int'($signed(b)) - int'(bin);
    exp_ovf  = (sd > 32767) || (sd < -32768);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.BIN   = bin;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_run", 32'(bus.busy), 32'd1);
    chk("done_early", 32'(bus.done), 32'd0);
    cnt = 1;
    while (bus.done !== 1'b1 && cnt < 20) begin
      if (glitch && cnt == 2) begin
        bus.start = 1'b1;
        bus.A     = 16'h0000;
        bus.B     = 16'h0001;
        bus.BIN   = 1'b0;
      end else begin
        bus.start = 1'b0;
        bus.A     = 16'($urandom);
        bus.B     = 16'($urandom);
        bus.BIN   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cnt++;
    end
    bus.start = 1'b0;
    chk("latency_edges", 32'(cnt - 1), 32'd4);
    chk("D", 32'(bus.D), 32'(exp_d));
    chk("BOUT", 32'(bus.BOUT), 32'(exp_bout));
`ifdef SUB_OVF_EN
    chk("OVF", 32'(bus.OVF), 32'(exp_ovf));
`endif
    chk("busy_done", 32'(bus.busy), 32'd1);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("extra_done", 32'(dones), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("D_hold", 32'(bus.D), 32'(exp_d));
    chk("BOUT_hold", 32'(bus.BOUT), 32'(exp_bout));
  endtask

  initial begin
    int dones;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = 16'h0000;
    bus.B     = 16'h0000;
    bus.BIN   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_D", 32'(bus.D), 32'd0);
    chk("rst_BOUT", 32'(bus.BOUT), 32'd0);
`ifdef SUB_OVF_EN
    chk("rst_OVF", 32'(bus.OVF), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h0234, 1'b0, 1'b0);
    chk("t1_D", 32'(bus.D), 32'h1000);
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
    chk("t2_D", 32'(bus.D), 32'hFFFF);
    chk("t2_BOUT", 32'(bus.BOUT), 32'd1);
    run_op(16'h0005, 16'h0003, 1'b1, 1'b0);
    chk("t3a_D", 32'(bus.D), 32'h0001);
    run_op(16'hABCD, 16'hABCD, 1'b0, 1'b0);
    chk("t3b_D", 32'(bus.D), 32'h0000);
    run_op(16'h0009, 16'h0004, 1'b0, 1'b1);
    chk("t4_D", 32'(bus.D), 32'h0005);
    run_op(16'h0003, 16'h0001, 1'b0, 1'b0);
    chk("t4_next_D", 32'(bus.D), 32'h0002);

    // Abort a run with reset two cycles after start.
    bus.start = 1'b1;
    bus.A     = 16'h1234;
    bus.B     = 16'h0001;
    bus.BIN   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_D", 32'(bus.D), 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    chk("t5_D", 32'(bus.D), 32'h00FE);

`ifdef SUB_OVF_EN
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
    chk("t6a_OVF", 32'(bus.OVF), 32'd1);
    chk("t6a_D", 32'(bus.D), 32'h7FFF);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
    chk("t6b_OVF", 32'(bus.OVF), 32'd1);
    chk("t6b_BOUT", 32'(bus.BOUT), 32'd1);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 8 == 1) ra = 16'h0000;
      if (i % 8 == 3) rb = 16'hFFFF;
      if (i % 8 == 5) rb = ra;
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'(i % 7 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
